// File: rtl/raster_block_sequencer.sv
// Raster-to-8x8-block reorder sequencer driving an external 2-bank line RAM.
// Writes fill 8-line strips; reads drain each full strip block by block.
module raster_block_sequencer #(
    parameter int IMG_WIDTH = 16,
    parameter int BIT_WIDTH = 8,
    localparam int AW = $clog2(16 * IMG_WIDTH)
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 i_valid,
    input  logic [BIT_WIDTH-1:0] i_data,
    output logic                 o_ready,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_waddr,
    output logic [BIT_WIDTH-1:0] mem_wdata,
    output logic                 mem_re,
    output logic [AW-1:0]        mem_raddr,
    input  logic [BIT_WIDTH-1:0] mem_rdata,
    output logic                 o_valid,
    output logic [BIT_WIDTH-1:0] o_data,
    output logic                 o_first,
    output logic                 o_last,
    input  logic                 i_ready
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int NB = IMG_WIDTH / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(NB - 1);
    localparam logic [AW-1:0] BANK_SZ = AW'(8 * IMG_WIDTH);
    localparam logic [AW-1:0] LINE_SZ = AW'(IMG_WIDTH);

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    state_t        state;
    logic [1:0]    full;
    logic          wbank;
    logic [2:0]    wrow;
    logic [CW-1:0] wcol;
    logic          rbank;
    logic [BW-1:0] blk;
    logic [2:0]    rrow;
    logic [2:0]    rcol;
    logic          wr_end;
    logic          rd_end;
    logic          go;

    assign o_ready   = !full[wbank];
    assign mem_we    = n_rst && i_valid && o_ready;
    assign mem_wdata = i_data;
    assign mem_waddr = (wbank ? BANK_SZ : '0)
                     + AW'(wrow) * LINE_SZ
                     + AW'(wcol);

    assign mem_re    = n_rst && (state == READ) && (!o_valid || i_ready);
    assign mem_raddr = (rbank ? BANK_SZ : '0)
                     + AW'(rrow) * LINE_SZ
                     + (AW'(blk) << 3)
                     + AW'(rcol);
    assign o_data    = mem_rdata;

    assign wr_end = mem_we && (wrow == 3'd7) && (wcol == COL_LAST);
    assign rd_end = mem_re && (blk == BLK_LAST)
                 && (rrow == 3'd7) && (rcol == 3'd7);
    // Start reading on the same edge the bank fills, saving a cycle.
    assign go = full[rbank] || (wr_end && (wbank == rbank));

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            full <= 2'b00;
        end else begin
            full[0] <= (full[0] && !(rd_end && !rbank)) || (wr_end && !wbank);
            full[1] <= (full[1] && !(rd_end && rbank)) || (wr_end && wbank);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wbank <= 1'b0;
            wrow  <= '0;
            wcol  <= '0;
        end else if (mem_we) begin
            if (wcol == COL_LAST) begin
                wcol <= '0;
                wrow <= wrow + 3'd1;
                if (wrow == 3'd7)
                    wbank <= !wbank;
            end else begin
                wcol <= wcol + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state   <= IDLE;
            rbank   <= 1'b0;
            blk     <= '0;
            rrow    <= '0;
            rcol    <= '0;
            o_valid <= 1'b0;
            o_first <= 1'b0;
            o_last  <= 1'b0;
        end else begin
            if (mem_re) begin
                o_valid <= 1'b1;
                o_first <= (rrow == 3'd0) && (rcol == 3'd0);
                o_last  <= (rrow == 3'd7) && (rcol == 3'd7);
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (go)
                        state <= READ;
                end
                READ: begin
                    if (mem_re) begin
                        rcol <= rcol + 3'd1;
                        if (rcol == 3'd7) begin
                            rrow <= rrow + 3'd1;
                            if (rrow == 3'd7) begin
                                if (blk == BLK_LAST) begin
                                    blk   <= '0;
                                    rbank <= !rbank;
                                    state <= IDLE;
                                end else begin
                                    blk <= blk + BW'(1);
                                end
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_raster_block_sequencer.sv
// Bench for raster_block_sequencer: RAM model, block-order reference model,
// output table, directed corner sequences and randomized handshakes.
module tb_raster_block_sequencer;

    localparam int W   = 16;
    localparam int AW  = 8;
    localparam int PIX = 8 * W;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          i_valid = 1'b0;
    logic [7:0]    i_data = 8'h00;
    logic          o_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;
    logic          mem_re;
    logic [AW-1:0] mem_raddr;
    logic [7:0]    mem_rdata = 8'h00;
    logic          o_valid;
    logic [7:0]    o_data;
    logic          o_first;
    logic          o_last;
    logic          i_ready = 1'b0;

    raster_block_sequencer #(.IMG_WIDTH(W), .BIT_WIDTH(8)) dut (
        .clk(clk), .n_rst(n_rst),
        .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .o_valid(o_valid), .o_data(o_data),
        .o_first(o_first), .o_last(o_last), .i_ready(i_ready)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [16*W];
    always @(posedge clk) begin
        if (mem_we) ram[mem_waddr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_raddr];
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic       f;
        logic       l;
    } obs_t;

    logic [7:0] acc [$];
    obs_t       out_q [$];
    int         acc_cnt = 0;
    int         out_cnt = 0;
    int         cyc = 0;
    int         wr128 = -1;
    int         first_re = -1;
    int         first_ov = -1;
    logic [AW-1:0] first_raddr = '0;
    bit         stall_p = 0;
    obs_t       stall_v;

    // Raster index of the j-th pixel in block order.
    function automatic int src_idx(input int j);
        int strip, k, b, r, c;
        strip = j / PIX;
        k = j % PIX;
        b = k / 64;
        r = (k % 64) / 8;
        c = k % 8;
        return strip * PIX + r * W + b * 8 + c;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!n_rst) begin
            stall_p = 0;
        end else begin
            if (i_valid && o_ready) begin
                chk("write_port", {mem_we, mem_waddr, mem_wdata},
                    {1'b1, AW'(acc_cnt % (16 * W)), i_data});
                acc.push_back(i_data);
                acc_cnt++;
                if (acc_cnt == 128 && wr128 < 0) wr128 = cyc;
            end else if (mem_we) begin
                chk("spurious_we", mem_we, 0);
            end
            if (mem_re && first_re < 0) begin
                first_re = cyc;
                first_raddr = mem_raddr;
            end
            if (o_valid && first_ov < 0) first_ov = cyc;
            if (stall_p)
                chk("stall_hold", {o_valid, o_data, o_first, o_last},
                    {1'b1, stall_v.d, stall_v.f, stall_v.l});
            stall_p = o_valid && !i_ready;
            stall_v = '{o_data, o_first, o_last};
            if (o_valid && i_ready) begin
                int s, k;
                s = src_idx(out_cnt);
                k = out_cnt % PIX;
                chk("out_src_avail", 32'(s < acc.size()), 1);
                if (s < acc.size())
                    chk("out_pix", {o_data, o_first, o_last},
                        {acc[s], 1'(k % 64 == 0), 1'(k % 64 == 63)});
                out_q.push_back('{o_data, o_first, o_last});
                out_cnt++;
            end
        end
    end

    task automatic do_reset(input int ncyc);
        i_valid = 0;
        i_ready = 0;
        n_rst = 0;
        repeat (ncyc) @(posedge clk);
        #1;
        acc.delete();
        out_q.delete();
        acc_cnt = 0;
        out_cnt = 0;
        wr128 = -1;
        first_re = -1;
        first_ov = -1;
        n_rst = 1;
        #1;
        chk("reset_state", {o_valid, o_first, o_last, mem_re, mem_we, o_ready},
            6'b000001);
    endtask

    task automatic stream(input int n, input int maxc, input int gap,
                          input bit rnd, input int base, output int sent);
        sent = 0;
        for (int c = 0; c < maxc && sent < n; c++) begin
            i_valid = ($urandom_range(99) >= gap);
            i_data = rnd ? 8'($urandom) : 8'(base + sent);
            @(negedge clk);
            if (i_valid && o_ready) sent++;
            @(posedge clk);
            #1;
        end
        i_valid = 0;
    endtask

    task automatic wait_out(input int target, input int maxc);
        for (int c = 0; c < maxc && out_cnt < target; c++) begin
            @(posedge clk);
            #1;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("drain_count", out_cnt, target);
    endtask

    typedef struct {
        int         idx;
        logic [7:0] d;
        logic       f;
        logic       l;
    } tvec_t;

    tvec_t tbl [10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sent;
        tbl[0] = '{0,   8'd0,   1'b1, 1'b0};
        tbl[1] = '{1,   8'd1,   1'b0, 1'b0};
        tbl[2] = '{7,   8'd7,   1'b0, 1'b0};
        tbl[3] = '{8,   8'd16,  1'b0, 1'b0};
        tbl[4] = '{56,  8'd112, 1'b0, 1'b0};
        tbl[5] = '{63,  8'd119, 1'b0, 1'b1};
        tbl[6] = '{64,  8'd8,   1'b1, 1'b0};
        tbl[7] = '{65,  8'd9,   1'b0, 1'b0};
        tbl[8] = '{120, 8'd120, 1'b0, 1'b0};
        tbl[9] = '{127, 8'd127, 1'b0, 1'b1};

        do_reset(3);

        // One strip 0..127, downstream always ready.
        i_ready = 1;
        stream(128, 200, 0, 0, 0, sent);
        chk("strip_sent", sent, 128);
        wait_out(128, 400);
        chk("first_re_lat", first_re, wr128 + 1);
        chk("first_raddr", first_raddr, 0);
        chk("first_ov_lat", first_ov, first_re + 1);
        chk("tbl_size", out_q.size(), 128);
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].idx < out_q.size())
                chk($sformatf("tbl_%0d", tbl[i].idx),
                    {out_q[tbl[i].idx].d, out_q[tbl[i].idx].f,
                     out_q[tbl[i].idx].l},
                    {tbl[i].d, tbl[i].f, tbl[i].l});
        end

        // Downstream stalled: both banks fill, then input backs up.
        do_reset(1);
        stream(320, 320, 0, 0, 0, sent);
        chk("stall_sent", sent, 256);
        chk("stall_acc", acc_cnt, 256);
        chk("stall_oready", o_ready, 0);
        i_ready = 1;
        wait_out(256, 800);

        // Four strips, random data, random gaps and random downstream ready.
        do_reset(1);
        fork
            begin
                stream(4 * PIX, 6000, 30, 1, 0, sent);
                chk("rand_sent", sent, 4 * PIX);
            end
            begin
                for (int c = 0; c < 6000 && out_cnt < 4 * PIX; c++) begin
                    i_ready = 1'($urandom_range(1));
                    @(posedge clk);
                    #1;
                end
                i_ready = 1;
            end
        join
        wait_out(4 * PIX, 200);

        // Reset mid-operation: a strip plus 70 pixels in, outputs flowing.
        do_reset(1);
        stream(128, 200, 0, 0, 100, sent);
        fork
            stream(70, 400, 0, 0, 200, sent);
            begin
                i_ready = 1;
                for (int c = 0; c < 300 && out_cnt < 10; c++) begin
                    @(posedge clk);
                    #1;
                end
                i_ready = 0;
            end
        join
        chk("pre_rst_acc", acc_cnt, 198);
        chk("pre_rst_out", 32'(out_cnt >= 10), 1);
        do_reset(1);
        i_valid = 1;
        i_data = 8'hA5;
        #1;
        chk("post_rst_waddr", {mem_we, mem_waddr}, {1'b1, 8'h00});
        i_ready = 1;
        stream(128, 300, 0, 0, 50, sent);
        chk("post_rst_sent", sent, 128);
        wait_out(128, 400);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
